// File: rtl/key_debouncer.sv
// Key input conditioning: per-key two-flop synchroniser, counter debounce,
// clean level, one-cycle press/release pulses and a press-driven toggle.
// Every key is handled by its own independent slice.
module key_debouncer #(
   parameter int clk_mhz         = 50,
   parameter int w_key           = 4,
   parameter int debounce_ms     = 10,
   parameter int debounce_cycles = clk_mhz * 1000 * debounce_ms,
   parameter bit key_active_low  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,          // asynchronous, active-low
   input  logic [w_key-1:0] key_raw,
   output logic [w_key-1:0] key_stable,
   output logic [w_key-1:0] key_pressed,
   output logic [w_key-1:0] key_released,
   output logic [w_key-1:0] key_toggle
);

   // Counter must hold values 0..D-1; sized for D so that D=1 still gets one bit.
   localparam int              CNT_W    = $clog2(debounce_cycles + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [w_key-1:0] w_key_in;     // logical key level, 1 = pressed
   logic [w_key-1:0] r_sync1;
   logic [w_key-1:0] r_sync2;
   logic [w_key-1:0] w_stable;     // debounced level gathered from the slices
   logic [w_key-1:0] r_stable_d;   // one-cycle delayed level for edge detection
   logic [w_key-1:0] w_rise;
   logic [w_key-1:0] w_fall;
   logic [w_key-1:0] r_pressed;
   logic [w_key-1:0] r_released;
   logic [w_key-1:0] r_toggle;

   // Normalise polarity before synchronising so reset value 0 means "not pressed".
   assign w_key_in = key_active_low ? ~key_raw : key_raw;

   // Two-flop synchroniser for the asynchronous key pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_key_in;
         r_sync2 <= r_sync1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < w_key; gi++) begin : g_key
         logic [CNT_W-1:0] r_cnt;
         logic             r_stable;

         // Accept a new level only after D consecutive differing samples;
         // any sample matching the current level discards the partial count.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else if (r_sync2[gi] == r_stable) begin
               r_cnt    <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_cnt    <= '0;
               r_stable <= r_sync2[gi];
            end else begin
               r_cnt    <= r_cnt + CNT_ONE;
            end
         end

         assign w_stable[gi] = r_stable;
      end
   endgenerate

   assign w_rise = w_stable & ~r_stable_d;
   assign w_fall = ~w_stable & r_stable_d;

   // Registered edge pulses and press toggle, one cycle after the level changes.
   // Reset clears both the level and its delayed copy, so no edge is seen on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stable_d <= '0;
         r_pressed  <= '0;
         r_released <= '0;
         r_toggle   <= '0;
      end else begin
         r_stable_d <= w_stable;
         r_pressed  <= w_rise;
         r_released <= w_fall;
         r_toggle   <= r_toggle ^ w_rise;
      end
   end

   assign key_stable   = w_stable;
   assign key_pressed  = r_pressed;
   assign key_released = r_released;
   assign key_toggle   = r_toggle;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with D = 4: one active-high instance for the
// main sequence and one active-low instance for polarity checks.
module tb_key_debouncer;

   logic       clk;
   logic       rst;
   logic [3:0] key_raw;
   logic [3:0] key_raw_lo;
   logic [3:0] stable,    pressed,    released,    toggle;
   logic [3:0] stable_lo, pressed_lo, released_lo, toggle_lo;

   int n_checks = 0;
   int n_errors = 0;

   key_debouncer #(.w_key(4), .debounce_cycles(4), .key_active_low(1'b0)) dut (
      .clk(clk), .rst(rst), .key_raw(key_raw),
      .key_stable(stable), .key_pressed(pressed),
      .key_released(released), .key_toggle(toggle)
   );

   key_debouncer #(.w_key(4), .debounce_cycles(4), .key_active_low(1'b1)) dut_lo (
      .clk(clk), .rst(rst), .key_raw(key_raw_lo),
      .key_stable(stable_lo), .key_pressed(pressed_lo),
      .key_released(released_lo), .key_toggle(toggle_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] pr,
                          input logic [3:0] rl, input logic [3:0] tg);
      chk({tag, ".stable"},   stable,   st);
      chk({tag, ".pressed"},  pressed,  pr);
      chk({tag, ".released"}, released, rl);
      chk({tag, ".toggle"},   toggle,   tg);
   endtask

   task automatic chk_lo(input string tag, input logic [3:0] st, input logic [3:0] tg);
      chk({tag, ".lo_stable"},   stable_lo,   st);
      chk({tag, ".lo_pressed"},  pressed_lo,  4'b0000);
      chk({tag, ".lo_released"}, released_lo, 4'b0000);
      chk({tag, ".lo_toggle"},   toggle_lo,   tg);
   endtask

   initial begin
      rst        = 1'b0;
      key_raw    = 4'h0;
      key_raw_lo = 4'hF;

      // 1: reset held while keys thrash, then released with keys idle
      for (int i = 0; i < 6; i++) begin
         key_raw = (i % 2 == 0) ? 4'hF : 4'h0;
         tick();
         chk_all("t1_in_reset", 4'b0, 4'b0, 4'b0, 4'b0);
      end
      key_raw = 4'h0;
      rst     = 1'b1;
      tick(10);
      chk_all("t1_after_release", 4'b0, 4'b0, 4'b0, 4'b0);
      chk_lo("t1_lo_idle", 4'b0, 4'b0);
      $display("step 1 reset behaviour done");

      // 2: key 0 press, level after D+2 edges, pulse one cycle later
      key_raw = 4'b0001;
      tick(5);
      chk_all("t2_before", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick();
      chk_all("t2_level",  4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick();
      chk_all("t2_pulse",  4'b0001, 4'b0001, 4'b0000, 4'b0001);
      tick();
      chk_all("t2_after",  4'b0001, 4'b0000, 4'b0000, 4'b0001);
      $display("step 2 single press done");

      // 3: key 1 bounces 1,1,1,0 five times, never reaches D consecutive samples
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 4; j++) begin
            key_raw = (j == 3) ? 4'b0001 : 4'b0011;
            tick();
            chk_all("t3_bounce", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
         end
      end
      key_raw = 4'b0011;
      tick(5);
      chk_all("t3_before", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      tick();
      chk_all("t3_level",  4'b0011, 4'b0000, 4'b0000, 4'b0001);
      tick();
      chk_all("t3_pulse",  4'b0011, 4'b0010, 4'b0000, 4'b0011);
      tick(3);
      $display("step 3 bounce rejection done");

      // 4: key 2 press, release, press again
      key_raw = 4'b0111;
      tick(6);
      chk_all("t4_press_level", 4'b0111, 4'b0000, 4'b0000, 4'b0011);
      tick();
      chk_all("t4_press_pulse", 4'b0111, 4'b0100, 4'b0000, 4'b0111);
      tick(3);
      key_raw = 4'b0011;
      tick(6);
      chk_all("t4_rel_level", 4'b0011, 4'b0000, 4'b0000, 4'b0111);
      tick();
      chk_all("t4_rel_pulse", 4'b0011, 4'b0000, 4'b0100, 4'b0111);
      tick();
      chk_all("t4_rel_after", 4'b0011, 4'b0000, 4'b0000, 4'b0111);
      tick(2);
      key_raw = 4'b0111;
      tick(7);
      chk_all("t4_press2_pulse", 4'b0111, 4'b0100, 4'b0000, 4'b0011);
      tick();
      chk_all("t4_press2_after", 4'b0111, 4'b0000, 4'b0000, 4'b0011);
      tick(2);
      $display("step 4 press/release/toggle done");

      // 5: key 0 releases and key 3 presses together; key 3 bounces once
      key_raw = 4'b1110;
      tick();
      key_raw = 4'b0110;
      tick();
      key_raw = 4'b1110;
      tick(3);
      chk_all("t5_n4", 4'b0111, 4'b0000, 4'b0000, 4'b0011);
      tick();
      chk_all("t5_k0_level", 4'b0110, 4'b0000, 4'b0000, 4'b0011);
      tick();
      chk_all("t5_k0_pulse", 4'b0110, 4'b0000, 4'b0001, 4'b0011);
      tick();
      chk_all("t5_k3_level", 4'b1110, 4'b0000, 4'b0000, 4'b0011);
      tick();
      chk_all("t5_k3_pulse", 4'b1110, 4'b1000, 4'b0000, 4'b1011);
      chk_lo("t5_lo_idle", 4'b0000, 4'b0000);
      key_raw_lo = 4'b1110;          // active-low key 0 pressed
      tick(6);
      chk_lo("t5_lo_level", 4'b0001, 4'b0000);
      tick(4);
      $display("step 5 independent keys and polarity done");

      // 6: reset during a count, then release with all keys held
      key_raw = 4'b1111;
      tick(4);
      rst = 1'b0;
      #1;
      chk_all("t6_reset_now", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      chk_lo("t6_lo_reset", 4'b0000, 4'b0000);
      tick(3);
      chk_all("t6_reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b1;
      tick(5);
      chk_all("t6_before", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick();
      chk_all("t6_level",  4'b1111, 4'b0000, 4'b0000, 4'b0000);
      tick();
      chk_all("t6_pulse",  4'b1111, 4'b1111, 4'b0000, 4'b1111);
      tick();
      chk_all("t6_after",  4'b1111, 4'b0000, 4'b0000, 4'b1111);
      $display("step 6 reset mid-count done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
